// File: rtl/seq_scan_ctrl.sv
// Word-fed serial pattern detector sequencer: accepts words over valid/ready,
// shifts them MSB-first through a programmable 1..PW bit matcher, counts matches.
module seq_scan_ctrl #(
  parameter int DW = 8,
  parameter int PW = 8,
  parameter int NW = 8,
  parameter int CW = 8,
  parameter int LW = $clog2(PW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [LW-1:0] pat_len,
  input  logic          overlap,
  input  logic [NW-1:0] num_words,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic          busy,
  output logic          match,
  output logic [CW-1:0] match_count,
  output logic          done
);

  localparam int BW = $clog2(DW);
  localparam logic [LW-1:0] PW_L = LW'(PW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Job configuration, latched on an accepted start.
  logic [PW-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic          ovl_q;
  logic [NW-1:0] words_left_q;

  // Serial datapath.
  logic [DW-1:0] shreg_q;
  logic [BW-1:0] bit_cnt_q;
  logic [PW-2:0] hist_q;
  logic [LW-1:0] fill_q;
  logic          match_q;
  logic [CW-1:0] match_count_q;

  logic          last_bit;
  logic          last_word;
  logic [LW-1:0] len_clamped;
  logic [PW-1:0] cand;
  logic [PW-1:0] len_mask;
  logic          window_full;
  logic          hit;
  logic [LW-1:0] fill_d;

  assign last_bit  = (bit_cnt_q == BW'(DW - 1));
  assign last_word = (words_left_q == NW'(1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    data_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (num_words == '0) ? DONE : LOAD;
      end
      LOAD: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (data_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = last_word ? DONE : LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Match evaluation for the bit currently at the head of the shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    len_clamped = pat_len;
    if (pat_len == '0)       len_clamped = LW'(1);
    else if (pat_len > PW_L) len_clamped = PW_L;
  end

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PW; i++) len_mask[i] = (LW'(i) < len_q);
  end

  assign cand        = {hist_q, shreg_q[DW-1]};
  // Only bits shifted since the last start or non-overlapping hit may match.
  assign window_full = ((LW+1)'(fill_q) + (LW+1)'(1)) >= (LW+1)'(len_q);
  assign hit         = (((cand ^ pat_q) & len_mask) == '0) && window_full;

  always_comb begin
    fill_d = fill_q;
    if (hit && !ovl_q)      fill_d = '0;
    else if (fill_q != PW_L) fill_d = fill_q + LW'(1);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q         <= '0;
      len_q         <= '0;
      ovl_q         <= 1'b0;
      words_left_q  <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      hist_q        <= '0;
      fill_q        <= '0;
      match_q       <= 1'b0;
      match_count_q <= '0;
    end else begin
      match_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q         <= pattern;
            len_q         <= len_clamped;
            ovl_q         <= overlap;
            words_left_q  <= num_words;
            match_count_q <= '0;
            hist_q        <= '0;
            fill_q        <= '0;
          end
        end
        LOAD: begin
          if (data_valid) begin
            shreg_q   <= data_in;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          shreg_q   <= shreg_q << 1;
          bit_cnt_q <= bit_cnt_q + BW'(1);
          hist_q    <= cand[PW-2:0];
          fill_q    <= fill_d;
          match_q   <= hit;
          if (hit && (match_count_q != '1)) match_count_q <= match_count_q + CW'(1);
          if (last_bit) words_left_q <= words_left_q - NW'(1);
        end
        default: ;
      endcase
    end
  end

  assign match       = match_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboarded bench for seq_scan_ctrl: a bit-stream reference model queues the
// stream positions of expected matches; a monitor pops them on each match pulse.
module tb_seq_scan_ctrl;

  localparam int DW = 8;
  localparam int PW = 8;
  localparam int NW = 8;
  localparam int CW = 8;
  localparam int LW = $clog2(PW + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [PW-1:0] pattern;
  logic [LW-1:0] pat_len;
  logic          overlap;
  logic [NW-1:0] num_words;
  logic [DW-1:0] data_in;
  logic          data_valid;

  logic          data_ready, busy, match, done;
  logic [CW-1:0] match_count;
  logic          data_ready2, busy2, match2, done2;
  logic [1:0]    match_count2;

  int n_checks = 0;
  int n_errors = 0;

  int             exp_q[$];
  int             exp_count;
  int             last_bit_idx = -1;
  int             mon_want;
  logic [DW-1:0]  job_words[$];

  seq_scan_ctrl #(.DW(DW), .PW(PW), .NW(NW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .num_words(num_words), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .match(match), .match_count(match_count), .done(done)
  );

  // Narrow-counter instance sharing all stimulus, for saturation.
  seq_scan_ctrl #(.DW(DW), .PW(PW), .NW(NW), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .num_words(num_words), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready2), .busy(busy2),
    .match(match2), .match_count(match_count2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: scan the job's bit stream; a match needs len bits since the
  // window start, which moves past each hit when overlap is off.
  task automatic build_expect(input logic [PW-1:0] pat, input int len, input bit ovl);
    bit s[$];
    int win;
    bit ok;
    win = 0;
    exp_q.delete();
    exp_count = 0;
    foreach (job_words[w])
      for (int k = 0; k < DW; k++) s.push_back(job_words[w][DW-1-k]);
    for (int i = 0; i < s.size(); i++) begin
      if (i - len + 1 >= win) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++)
          if (s[i-len+1+j] != pat[len-1-j]) ok = 1'b0;
        if (ok) begin
          exp_q.push_back(i);
          exp_count++;
          if (!ovl) win = i + 1;
        end
      end
    end
  endtask

  // Each match pulse must belong to the bit shifted on the preceding edge.
  always @(negedge clk) begin
    if (match) begin
      mon_want = (exp_q.size() != 0) ? exp_q.pop_front() : -2;
      check("match_pos", last_bit_idx, mon_want);
      check("match_sat_inst", match2, 1);
    end
  end

  task automatic check_end(input int cnt);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("ready_at_done", data_ready, 0);
    check("count", match_count, cnt);
    check("done_sat_inst", done2, 1);
    check("busy_sat_inst", busy2, 0);
    check("ready_sat_inst", data_ready2, 0);
    check("count_sat", match_count2, (cnt > 3) ? 3 : cnt);
    @(posedge clk); last_bit_idx = -1;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  // Runs job_words as one job; stall_word gets 5 idle LOAD cycles and a stray start.
  task automatic run_job(input logic [PW-1:0] pat, input logic [LW-1:0] plen,
                         input bit ovl, input int stall_word);
    int len_eff;
    int nw;
    len_eff = (plen == 0) ? 1 : ((int'(plen) > PW) ? PW : int'(plen));
    nw = job_words.size();
    build_expect(pat, len_eff, ovl);
    pattern = pat; pat_len = plen; overlap = ovl; num_words = NW'(nw); start = 1'b1;
    @(posedge clk); last_bit_idx = -1;
    @(negedge clk);
    start = 1'b0; pattern = ~pat; pat_len = LW'(1); overlap = ~ovl; num_words = NW'(1);
    check("busy_start", busy, 1);
    for (int w = 0; w < nw; w++) begin
      data_in = job_words[w];
      if (w == stall_word) begin
        data_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
          check("ready_stall", data_ready, 1);
          start = (c == 2);
          @(posedge clk); last_bit_idx = -1;
          @(negedge clk);
        end
        start = 1'b0;
      end
      data_valid = 1'b1;
      check("ready_load", data_ready, 1);
      @(posedge clk); last_bit_idx = -1;
      @(negedge clk);
      data_valid = 1'b0;
      check("ready_shift", data_ready, 0);
      for (int k = 0; k < DW; k++) begin
        @(posedge clk); last_bit_idx = w * DW + k;
        @(negedge clk);
      end
    end
    check_end(exp_count);
    check("missed_match", exp_q.size(), 0);
  endtask

  task automatic zero_job();
    exp_q.delete();
    pattern = 8'h01; pat_len = LW'(1); overlap = 1'b1; num_words = '0; start = 1'b1;
    @(posedge clk); last_bit_idx = -1;
    @(negedge clk);
    start = 1'b0;
    check_end(0);
  endtask

  // Reset lands while word 2 of 3 has 7 of 8 bits shifted; all outputs must clear.
  task automatic reset_mid_job();
    exp_q.delete();
    pattern = 8'h05; pat_len = LW'(4); overlap = 1'b1; num_words = NW'(3); start = 1'b1;
    @(posedge clk); last_bit_idx = -1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      data_in = (w == 0) ? 8'h00 : 8'h02;
      data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      for (int k = 0; k < ((w == 0) ? DW : DW - 1); k++) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
    check("rst_count_sat", match_count2, 0);
    @(negedge clk);
    check("rst_idle_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; pat_len = '0; overlap = 1'b0;
    num_words = '0; data_in = '0; data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", data_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_match", match, 0);
    check("reset_done", done, 0);
    check("reset_count", match_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Overlapping then non-overlapping on 0x55.
    job_words.delete(); job_words.push_back(8'h55);
    run_job(8'h05, LW'(4), 1'b1, -1);
    run_job(8'h05, LW'(4), 1'b0, -1);

    // Match spanning a word boundary; stalled LOAD and ignored start mid-job.
    job_words.delete(); job_words.push_back(8'h05); job_words.push_back(8'h40);
    run_job(8'h05, LW'(4), 1'b1, 1);
    run_job(8'h05, LW'(4), 1'b0, -1);

    // Empty job after a nonzero count.
    zero_job();

    // Length 0 clamps to 1: eight hits, narrow counter saturates at 3.
    job_words.delete(); job_words.push_back(8'hFF);
    run_job(8'h01, LW'(0), 1'b0, -1);

    // Length above PW clamps to PW.
    job_words.delete(); job_words.push_back(8'hA5); job_words.push_back(8'hA5);
    run_job(8'hA5, LW'(15), 1'b1, -1);

    reset_mid_job();
    job_words.delete(); job_words.push_back(8'h40);
    run_job(8'h05, LW'(4), 1'b1, -1);

    // Random three-word jobs with short patterns.
    for (int r = 0; r < 4; r++) begin
      job_words.delete();
      for (int w = 0; w < 3; w++) job_words.push_back(DW'($urandom));
      run_job(PW'($urandom), LW'(2 + (r % 3)), bit'(r % 2), (r == 2) ? 2 : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
